// File: rtl/clint_ctrl_if.sv
// Trap-sequencer bus: ID/EX pipeline taps, CSR read/write channel and redirect to ctrl.
// The slave modport is the clint_ctrl side; master is the pipeline/CSR-file side.
interface clint_ctrl_if;
    localparam int unsigned XLEN    = 64;
    localparam int unsigned ILEN    = 32;
    localparam int unsigned CSR_AW  = 12;

    logic [ILEN-1:0]   inst_i;
    logic [XLEN-1:0]   inst_addr_i;
    logic              jump_flag_i;
    logic [XLEN-1:0]   jump_addr_i;
    logic              timer_irq_i;
    logic [XLEN-1:0]   csr_mtvec_i;
    logic [XLEN-1:0]   csr_mepc_i;
    logic [XLEN-1:0]   csr_mstatus_i;
    logic              stall_flag_o;
    logic              csr_we_o;
    logic [CSR_AW-1:0] csr_waddr_o;
    logic [XLEN-1:0]   csr_wdata_o;
    logic              int_assert_o;
    logic [XLEN-1:0]   int_addr_o;

    modport slave (
        input  inst_i, inst_addr_i, jump_flag_i, jump_addr_i, timer_irq_i,
        input  csr_mtvec_i, csr_mepc_i, csr_mstatus_i,
        output stall_flag_o, csr_we_o, csr_waddr_o, csr_wdata_o,
        output int_assert_o, int_addr_o
    );

    modport master (
        output inst_i, inst_addr_i, jump_flag_i, jump_addr_i, timer_irq_i,
        output csr_mtvec_i, csr_mepc_i, csr_mstatus_i,
        input  stall_flag_o, csr_we_o, csr_waddr_o, csr_wdata_o,
        input  int_assert_o, int_addr_o
    );
endinterface

// File: rtl/clint_ctrl.sv
// Trap sequencer: arbitrates ECALL/EBREAK, machine timer and MRET, then runs the
// fixed mepc/mcause/mstatus update sequence and issues a one-cycle redirect.
module clint_ctrl (
    input  logic          clk,
    input  logic          rst,
    clint_ctrl_if.slave   bus
);
    localparam int unsigned XLEN   = 64;
    localparam int unsigned ILEN   = 32;
    localparam int unsigned CSR_AW = 12;

    localparam logic [ILEN-1:0]   INST_ECALL  = 32'h0000_0073;
    localparam logic [ILEN-1:0]   INST_EBREAK = 32'h0010_0073;
    localparam logic [ILEN-1:0]   INST_MRET   = 32'h3020_0073;

    localparam logic [CSR_AW-1:0] CSR_MSTATUS = 12'h300;
    localparam logic [CSR_AW-1:0] CSR_MEPC    = 12'h341;
    localparam logic [CSR_AW-1:0] CSR_MCAUSE  = 12'h342;

    localparam logic [XLEN-1:0]   CAUSE_ECALL  = 64'd11;
    localparam logic [XLEN-1:0]   CAUSE_EBREAK = 64'd3;
    localparam logic [XLEN-1:0]   CAUSE_TIMER  = 64'h8000_0000_0000_0007;

    localparam int unsigned MIE_BIT  = 3;
    localparam int unsigned MPIE_BIT = 7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_W_MEPC,
        S_W_MCAUSE,
        S_W_MSTATUS,
        S_ASSERT_TRAP,
        S_W_MSTATUS_MRET,
        S_ASSERT_MRET
    } state_e;

    state_e              state_q, state_d;
    logic [XLEN-1:0]     cause_q, cause_d;
    logic                csr_we_q, csr_we_d;
    logic [CSR_AW-1:0]   csr_waddr_q, csr_waddr_d;
    logic [XLEN-1:0]     csr_wdata_q, csr_wdata_d;
    logic                int_assert_q, int_assert_d;
    logic [XLEN-1:0]     int_addr_q, int_addr_d;

    logic                is_idle;
    logic                is_ecall;
    logic                is_ebreak;
    logic                is_mret;
    logic                timer_pend;
    logic                sync_exc;
    logic [XLEN-1:0]     epc;
    logic [XLEN-1:0]     mstatus_trap;
    logic [XLEN-1:0]     mstatus_mret;

    // Event decode; only meaningful while IDLE.
    always_comb begin
        is_idle    = (state_q == S_IDLE);
        is_ecall   = (bus.inst_i == INST_ECALL);
        is_ebreak  = (bus.inst_i == INST_EBREAK);
        is_mret    = (bus.inst_i == INST_MRET);
        timer_pend = bus.timer_irq_i & bus.csr_mstatus_i[MIE_BIT];
        sync_exc   = is_ecall | is_ebreak;

        // A timer trap resumes at the taken branch target so the jump is not lost.
        if (sync_exc || !bus.jump_flag_i) begin
            epc = bus.inst_addr_i;
        end else begin
            epc = bus.jump_addr_i;
        end

        mstatus_trap           = bus.csr_mstatus_i;
        mstatus_trap[MPIE_BIT] = bus.csr_mstatus_i[MIE_BIT];
        mstatus_trap[MIE_BIT]  = 1'b0;

        mstatus_mret           = bus.csr_mstatus_i;
        mstatus_mret[MIE_BIT]  = bus.csr_mstatus_i[MPIE_BIT];
        mstatus_mret[MPIE_BIT] = 1'b1;
    end

    // Next state and next registered outputs (outputs belong to the state being entered).
    always_comb begin
        state_d      = state_q;
        cause_d      = cause_q;
        csr_we_d     = 1'b0;
        csr_waddr_d  = '0;
        csr_wdata_d  = '0;
        int_assert_d = 1'b0;
        int_addr_d   = '0;

        unique case (state_q)
            S_IDLE: begin
                if (sync_exc || timer_pend) begin
                    if (is_ecall) begin
                        cause_d = CAUSE_ECALL;
                    end else if (is_ebreak) begin
                        cause_d = CAUSE_EBREAK;
                    end else begin
                        cause_d = CAUSE_TIMER;
                    end
                    state_d     = S_W_MEPC;
                    csr_we_d    = 1'b1;
                    csr_waddr_d = CSR_MEPC;
                    csr_wdata_d = epc;
                end else if (is_mret) begin
                    state_d     = S_W_MSTATUS_MRET;
                    csr_we_d    = 1'b1;
                    csr_waddr_d = CSR_MSTATUS;
                    csr_wdata_d = mstatus_mret;
                end
            end
            S_W_MEPC: begin
                state_d     = S_W_MCAUSE;
                csr_we_d    = 1'b1;
                csr_waddr_d = CSR_MCAUSE;
                csr_wdata_d = cause_q;
            end
            S_W_MCAUSE: begin
                state_d     = S_W_MSTATUS;
                csr_we_d    = 1'b1;
                csr_waddr_d = CSR_MSTATUS;
                csr_wdata_d = mstatus_trap;
            end
            S_W_MSTATUS: begin
                state_d      = S_ASSERT_TRAP;
                int_assert_d = 1'b1;
                int_addr_d   = bus.csr_mtvec_i & ~64'h3;
            end
            S_ASSERT_TRAP: begin
                state_d = S_IDLE;
            end
            S_W_MSTATUS_MRET: begin
                state_d      = S_ASSERT_MRET;
                int_assert_d = 1'b1;
                int_addr_d   = bus.csr_mepc_i;
            end
            S_ASSERT_MRET: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cause_q      <= '0;
            csr_we_q     <= 1'b0;
            csr_waddr_q  <= '0;
            csr_wdata_q  <= '0;
            int_assert_q <= 1'b0;
            int_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            cause_q      <= cause_d;
            csr_we_q     <= csr_we_d;
            csr_waddr_q  <= csr_waddr_d;
            csr_wdata_q  <= csr_wdata_d;
            int_assert_q <= int_assert_d;
            int_addr_q   <= int_addr_d;
        end
    end

    // Stall covers the detection cycle combinationally so ID does not advance past the event.
    assign bus.stall_flag_o = !is_idle || sync_exc || timer_pend || is_mret;
    assign bus.csr_we_o     = csr_we_q;
    assign bus.csr_waddr_o  = csr_waddr_q;
    assign bus.csr_wdata_o  = csr_wdata_q;
    assign bus.int_assert_o = int_assert_q;
    assign bus.int_addr_o   = int_addr_q;
endmodule

// File: tb/tb_clint_ctrl.sv
// Directed bench for clint_ctrl: trap, timer, MRET, priority, mid-sequence reset and EBREAK.
module tb_clint_ctrl;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] ECALL  = 32'h0000_0073;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [31:0] MRET   = 32'h3020_0073;

    logic clk = 1'b0;
    logic rst;
    int   pass_n  = 0;
    int   total_n = 0;

    always #5 clk = ~clk;

    clint_ctrl_if bus ();

    clint_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        total_n++;
        if ({bus.stall_flag_o, bus.csr_we_o, bus.csr_waddr_o, bus.csr_wdata_o, bus.int_assert_o, bus.int_addr_o} !== 143'd0)
            $display("FAIL reset_outputs: got stall=%b we=%b waddr=%h wdata=%h assert=%b addr=%h, want all 0",
                     bus.stall_flag_o, bus.csr_we_o, bus.csr_waddr_o, bus.csr_wdata_o, bus.int_assert_o, bus.int_addr_o);
        else pass_n++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_ecall;
        bus.csr_mstatus_i = 64'h8;
        bus.csr_mtvec_i   = 64'h8000_1000;
        bus.inst_addr_i   = 64'h8000_0010;
        bus.inst_i        = ECALL;
        #1;
        total_n++;
        if (bus.stall_flag_o !== 1'b1) $display("FAIL ecall_T_stall: got %b want 1", bus.stall_flag_o);
        else pass_n++;
        @(negedge clk);
        bus.inst_i = NOP;
        #1;
        total_n++;
        if ({bus.stall_flag_o, bus.csr_we_o, bus.csr_waddr_o, bus.csr_wdata_o} !== {1'b1, 1'b1, 12'h341, 64'h8000_0010})
            $display("FAIL ecall_mepc: got stall=%b we=%b %h=%h want 1 1 341=8000_0010",
                     bus.stall_flag_o, bus.csr_we_o, bus.csr_waddr_o, bus.csr_wdata_o);
        else pass_n++;
        @(negedge clk);
        #1;
        total_n++;
        if ({bus.stall_flag_o, bus.csr_we_o, bus.csr_waddr_o, bus.csr_wdata_o} !== {1'b1, 1'b1, 12'h342, 64'd11})
            $display("FAIL ecall_mcause: got stall=%b we=%b %h=%h want 1 1 342=b",
                     bus.stall_flag_o, bus.csr_we_o, bus.csr_waddr_o, bus.csr_wdata_o);
        else pass_n++;
        @(negedge clk);
        #1;
        total_n++;
        if ({bus.stall_flag_o, bus.csr_we_o, bus.csr_waddr_o, bus.csr_wdata_o} !== {1'b1, 1'b1, 12'h300, 64'h80})
            $display("FAIL ecall_mstatus: got stall=%b we=%b %h=%h want 1 1 300=80",
                     bus.stall_flag_o, bus.csr_we_o, bus.csr_waddr_o, bus.csr_wdata_o);
        else pass_n++;
        @(negedge clk);
        bus.csr_mstatus_i = 64'h80;
        #1;
        total_n++;
        if ({bus.stall_flag_o, bus.csr_we_o, bus.int_assert_o, bus.int_addr_o} !== {1'b1, 1'b0, 1'b1, 64'h8000_1000})
            $display("FAIL ecall_assert: got stall=%b we=%b assert=%b addr=%h want 1 0 1 8000_1000",
                     bus.stall_flag_o, bus.csr_we_o, bus.int_assert_o, bus.int_addr_o);
        else pass_n++;
        @(negedge clk);
        #1;
        total_n++;
        if ({bus.stall_flag_o, bus.csr_we_o, bus.int_assert_o} !== 3'b000)
            $display("FAIL ecall_idle: got stall=%b we=%b assert=%b want 000",
                     bus.stall_flag_o, bus.csr_we_o, bus.int_assert_o);
        else pass_n++;
    endtask

    task automatic test_mret;
        bus.csr_mepc_i = 64'h8000_0014;
        bus.inst_i     = MRET;
        #1;
        total_n++;
        if (bus.stall_flag_o !== 1'b1) $display("FAIL mret_T_stall: got %b want 1", bus.stall_flag_o);
        else pass_n++;
        @(negedge clk);
        bus.inst_i = NOP;
        #1;
        total_n++;
        if ({bus.stall_flag_o, bus.csr_we_o, bus.csr_waddr_o, bus.csr_wdata_o} !== {1'b1, 1'b1, 12'h300, 64'h88})
            $display("FAIL mret_mstatus: got stall=%b we=%b %h=%h want 1 1 300=88",
                     bus.stall_flag_o, bus.csr_we_o, bus.csr_waddr_o, bus.csr_wdata_o);
        else pass_n++;
        @(negedge clk);
        bus.csr_mstatus_i = 64'h88;
        #1;
        total_n++;
        if ({bus.stall_flag_o, bus.csr_we_o, bus.int_assert_o, bus.int_addr_o} !== {1'b1, 1'b0, 1'b1, 64'h8000_0014})
            $display("FAIL mret_assert: got stall=%b we=%b assert=%b addr=%h want 1 0 1 8000_0014",
                     bus.stall_flag_o, bus.csr_we_o, bus.int_assert_o, bus.int_addr_o);
        else pass_n++;
        @(negedge clk);
        #1;
        total_n++;
        if ({bus.stall_flag_o, bus.csr_we_o, bus.int_assert_o} !== 3'b000)
            $display("FAIL mret_idle: got stall=%b we=%b assert=%b want 000",
                     bus.stall_flag_o, bus.csr_we_o, bus.int_assert_o);
        else pass_n++;
    endtask

    task automatic test_timer;
        bus.timer_irq_i = 1'b1;
        bus.jump_flag_i = 1'b1;
        bus.jump_addr_i = 64'h8000_0200;
        bus.inst_addr_i = 64'h8000_0100;
        #1;
        total_n++;
        if (bus.stall_flag_o !== 1'b1) $display("FAIL timer_T_stall: got %b want 1", bus.stall_flag_o);
        else pass_n++;
        @(negedge clk);
        bus.jump_flag_i = 1'b0;
        #1;
        total_n++;
        if ({bus.csr_we_o, bus.csr_waddr_o, bus.csr_wdata_o} !== {1'b1, 12'h341, 64'h8000_0200})
            $display("FAIL timer_mepc: got we=%b %h=%h want 1 341=8000_0200", bus.csr_we_o, bus.csr_waddr_o, bus.csr_wdata_o);
        else pass_n++;
        @(negedge clk);
        #1;
        total_n++;
        if ({bus.csr_we_o, bus.csr_waddr_o, bus.csr_wdata_o} !== {1'b1, 12'h342, 64'h8000_0000_0000_0007})
            $display("FAIL timer_mcause: got we=%b %h=%h want 1 342=8000000000000007", bus.csr_we_o, bus.csr_waddr_o, bus.csr_wdata_o);
        else pass_n++;
        @(negedge clk);
        #1;
        total_n++;
        if ({bus.csr_we_o, bus.csr_waddr_o, bus.csr_wdata_o} !== {1'b1, 12'h300, 64'h80})
            $display("FAIL timer_mstatus: got we=%b %h=%h want 1 300=80", bus.csr_we_o, bus.csr_waddr_o, bus.csr_wdata_o);
        else pass_n++;
        @(negedge clk);
        bus.csr_mstatus_i = 64'h80;
        #1;
        total_n++;
        if ({bus.int_assert_o, bus.int_addr_o} !== {1'b1, 64'h8000_1000})
            $display("FAIL timer_assert: got assert=%b addr=%h want 1 8000_1000", bus.int_assert_o, bus.int_addr_o);
        else pass_n++;
        // Timer level stays high with MIE now clear: nothing may happen.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            total_n++;
            if ({bus.stall_flag_o, bus.csr_we_o, bus.int_assert_o} !== 3'b000)
                $display("FAIL timer_mie0_quiet[%0d]: got stall=%b we=%b assert=%b want 000",
                         i, bus.stall_flag_o, bus.csr_we_o, bus.int_assert_o);
            else pass_n++;
        end
        bus.timer_irq_i = 1'b0;
    endtask

    task automatic test_ecall_timer;
        bus.csr_mstatus_i = 64'h8;
        bus.timer_irq_i   = 1'b1;
        bus.inst_addr_i   = 64'h8000_0030;
        bus.inst_i        = ECALL;
        @(negedge clk);
        bus.inst_i = NOP;
        #1;
        total_n++;
        if ({bus.csr_we_o, bus.csr_waddr_o, bus.csr_wdata_o} !== {1'b1, 12'h341, 64'h8000_0030})
            $display("FAIL prio_mepc: got we=%b %h=%h want 1 341=8000_0030", bus.csr_we_o, bus.csr_waddr_o, bus.csr_wdata_o);
        else pass_n++;
        @(negedge clk);
        #1;
        total_n++;
        if ({bus.csr_we_o, bus.csr_waddr_o, bus.csr_wdata_o} !== {1'b1, 12'h342, 64'd11})
            $display("FAIL prio_mcause: got we=%b %h=%h want 1 342=b", bus.csr_we_o, bus.csr_waddr_o, bus.csr_wdata_o);
        else pass_n++;
        @(negedge clk);
        @(negedge clk);
        bus.csr_mstatus_i = 64'h80;
        #1;
        total_n++;
        if (bus.int_assert_o !== 1'b1) $display("FAIL prio_assert: got %b want 1", bus.int_assert_o);
        else pass_n++;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            total_n++;
            if ({bus.stall_flag_o, bus.csr_we_o, bus.int_assert_o} !== 3'b000)
                $display("FAIL prio_no_retake[%0d]: got stall=%b we=%b assert=%b want 000",
                         i, bus.stall_flag_o, bus.csr_we_o, bus.int_assert_o);
            else pass_n++;
        end
        bus.timer_irq_i = 1'b0;
    endtask

    task automatic test_reset_mid;
        bus.csr_mstatus_i = 64'h8;
        bus.inst_addr_i   = 64'h8000_0040;
        bus.inst_i        = ECALL;
        @(negedge clk);
        bus.inst_i = NOP;
        #1;
        total_n++;
        if ({bus.csr_we_o, bus.csr_waddr_o, bus.csr_wdata_o} !== {1'b1, 12'h341, 64'h8000_0040})
            $display("FAIL rstmid_mepc: got we=%b %h=%h want 1 341=8000_0040", bus.csr_we_o, bus.csr_waddr_o, bus.csr_wdata_o);
        else pass_n++;
        @(negedge clk);
        rst = 1'b1;
        #1;
        total_n++;
        if ({bus.csr_we_o, bus.csr_waddr_o, bus.csr_wdata_o} !== {1'b1, 12'h342, 64'd11})
            $display("FAIL rstmid_mcause: got we=%b %h=%h want 1 342=b", bus.csr_we_o, bus.csr_waddr_o, bus.csr_wdata_o);
        else pass_n++;
        @(negedge clk);
        rst = 1'b0;
        #1;
        total_n++;
        if ({bus.stall_flag_o, bus.csr_we_o, bus.csr_waddr_o, bus.csr_wdata_o, bus.int_assert_o, bus.int_addr_o} !== 143'd0)
            $display("FAIL rstmid_zero: got stall=%b we=%b waddr=%h wdata=%h assert=%b addr=%h want all 0",
                     bus.stall_flag_o, bus.csr_we_o, bus.csr_waddr_o, bus.csr_wdata_o, bus.int_assert_o, bus.int_addr_o);
        else pass_n++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            total_n++;
            if ({bus.stall_flag_o, bus.csr_we_o, bus.int_assert_o} !== 3'b000)
                $display("FAIL rstmid_aborted[%0d]: got stall=%b we=%b assert=%b want 000",
                         i, bus.stall_flag_o, bus.csr_we_o, bus.int_assert_o);
            else pass_n++;
        end
    endtask

    task automatic test_ebreak;
        bus.csr_mstatus_i = 64'h8;
        bus.csr_mtvec_i   = 64'h8000_1003;
        bus.inst_addr_i   = 64'h8000_0050;
        bus.inst_i        = EBREAK;
        @(negedge clk);
        bus.inst_i = NOP;
        #1;
        total_n++;
        if ({bus.csr_we_o, bus.csr_waddr_o, bus.csr_wdata_o} !== {1'b1, 12'h341, 64'h8000_0050})
            $display("FAIL ebreak_mepc: got we=%b %h=%h want 1 341=8000_0050", bus.csr_we_o, bus.csr_waddr_o, bus.csr_wdata_o);
        else pass_n++;
        @(negedge clk);
        #1;
        total_n++;
        if ({bus.csr_we_o, bus.csr_waddr_o, bus.csr_wdata_o} !== {1'b1, 12'h342, 64'd3})
            $display("FAIL ebreak_mcause: got we=%b %h=%h want 1 342=3", bus.csr_we_o, bus.csr_waddr_o, bus.csr_wdata_o);
        else pass_n++;
        @(negedge clk);
        #1;
        total_n++;
        if ({bus.csr_we_o, bus.csr_waddr_o, bus.csr_wdata_o} !== {1'b1, 12'h300, 64'h80})
            $display("FAIL ebreak_mstatus: got we=%b %h=%h want 1 300=80", bus.csr_we_o, bus.csr_waddr_o, bus.csr_wdata_o);
        else pass_n++;
        @(negedge clk);
        bus.csr_mstatus_i = 64'h80;
        #1;
        total_n++;
        if ({bus.csr_we_o, bus.int_assert_o, bus.int_addr_o} !== {1'b0, 1'b1, 64'h8000_1000})
            $display("FAIL ebreak_assert: got we=%b assert=%b addr=%h want 0 1 8000_1000",
                     bus.csr_we_o, bus.int_assert_o, bus.int_addr_o);
        else pass_n++;
        @(negedge clk);
        #1;
        total_n++;
        if ({bus.stall_flag_o, bus.int_assert_o} !== 2'b00)
            $display("FAIL ebreak_idle: got stall=%b assert=%b want 00", bus.stall_flag_o, bus.int_assert_o);
        else pass_n++;
    endtask

    initial begin
        rst               = 1'b1;
        bus.inst_i        = NOP;
        bus.inst_addr_i   = '0;
        bus.jump_flag_i   = 1'b0;
        bus.jump_addr_i   = '0;
        bus.timer_irq_i   = 1'b0;
        bus.csr_mtvec_i   = '0;
        bus.csr_mepc_i    = '0;
        bus.csr_mstatus_i = '0;
        @(negedge clk);
        test_reset();
        test_ecall();
        test_mret();
        test_timer();
        test_ecall_timer();
        test_reset_mid();
        test_ebreak();
        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
endmodule

// File: doc/clint_ctrl.md
# clint_ctrl

Trap sequencer for the RV64 core: decodes the instruction/PC pair held by the ID-stage CLINT pipeline register, arbitrates between synchronous exceptions (ECALL/EBREAK), the machine timer interrupt and MRET, and runs a fixed multi-cycle CSR update sequence. It stalls the pipeline while sequencing, then issues a one-cycle redirect to ctrl, which flushes the pipeline and jumps to the trap vector or return address.

## Interface
- No parameters. CSR addresses are fixed: mstatus 12'h300, mtvec 12'h305, mepc 12'h341, mcause 12'h342.
- Clocking: one clock; reset is synchronous and active-high.
- clk  input  1  core clock
- rst  input  1  synchronous active-high reset
- inst_i  input  32  instruction from ID-stage CLINT register
- inst_addr_i  input  64  PC of inst_i
- jump_flag_i  input  1  EX-stage branch/jump taken this cycle
- jump_addr_i  input  64  EX-stage jump target
- timer_irq_i  input  1  machine timer interrupt, level
- csr_mtvec_i  input  64  current mtvec (combinational read)
- csr_mepc_i  input  64  current mepc
- csr_mstatus_i  input  64  current mstatus
- stall_flag_o  output  1  hold request to ctrl
- csr_we_o  output  1  CSR write enable
- csr_waddr_o  output  12  CSR write address
- csr_wdata_o  output  64  CSR write data
- int_assert_o  output  1  one-cycle redirect request to ctrl
- int_addr_o  output  64  redirect target

## Operation
- Decode: ECALL = 32'h00000073, EBREAK = 32'h00100073, MRET = 32'h30200073. Timer interrupt is pending when timer_irq_i = 1 and mstatus[3] (MIE) = 1.
- Priority in IDLE: ECALL/EBREAK > timer interrupt > MRET. Non-winning events are not latched; a timer level stays pending by itself.
- States: IDLE, W_MEPC, W_MCAUSE, W_MSTATUS, ASSERT_TRAP, W_MSTATUS_MRET, ASSERT_MRET.
- IDLE -> W_MEPC on ECALL, EBREAK or timer. At detection, latch:
  - cause: ECALL 64'd11, EBREAK 64'd3, timer 64'h8000_0000_0000_0007.
  - epc: inst_addr_i for sync exceptions; for timer, jump_addr_i if jump_flag_i is set, else inst_addr_i.
- W_MEPC: write mepc = latched epc. -> W_MCAUSE.
- W_MCAUSE: write mcause = latched cause. -> W_MSTATUS.
- W_MSTATUS: write mstatus with bit7 (MPIE) = current bit3, bit3 = 0, other bits unchanged. -> ASSERT_TRAP.
- ASSERT_TRAP: int_assert_o = 1, int_addr_o = {csr_mtvec_i[63:2], 2'b00}. -> IDLE.
- IDLE -> W_MSTATUS_MRET on MRET when no higher-priority event is present.
- W_MSTATUS_MRET: write mstatus with bit3 = current bit7, bit7 = 1, other bits unchanged. -> ASSERT_MRET.
- ASSERT_MRET: int_assert_o = 1, int_addr_o = csr_mepc_i. -> IDLE.
- Outputs:
  - csr_we_o, csr_waddr_o, csr_wdata_o, int_assert_o and int_addr_o are registered and valid during the named state.
  - stall_flag_o = (state != IDLE) | event detected in IDLE. This term is combinational.
- All inputs other than the CSR reads are ignored outside IDLE.

## Timing
- Reset: state = IDLE. All outputs are 0 on the cycle after rst is sampled high, including csr_waddr_o, csr_wdata_o and int_addr_o. Reset mid-sequence aborts the sequence: no further CSR writes and no redirect.
- Trap latency, with detection in cycle T:
  - T: stall = 1.
  - T+1: mepc write.
  - T+2: mcause write.
  - T+3: mstatus write.
  - T+4: int_assert_o.
  - T+5: IDLE, stall = 0 unless a new event is present.
- MRET latency: T+1 mstatus write, T+2 int_assert_o, T+3 IDLE.
- Exactly one CSR write per write state. csr_we_o is 0 in IDLE and ASSERT states.
- mtvec and mepc are sampled in the cycle before the ASSERT state, so the value is registered at ASSERT. Earlier writes have already landed (CSR file write-then-read latency is one cycle).
- ECALL and timer arriving together: ECALL is taken. The timer is not re-taken while MIE = 0, which holds until MRET.
- ctrl flushes id_clint on int_assert_o, so inst_i is NOP at T+5. A held ECALL does not retrigger.

## Test plan
- ECALL at PC 64'h8000_0010, mtvec 64'h8000_1000, mstatus 64'h8 -> writes, one per cycle:
  - mepc 64'h8000_0010
  - mcause 64'd11
  - mstatus 64'h80
  - then int_assert_o with int_addr_o 64'h8000_1000 at T+4; stall high for T..T+4.
- timer_irq_i = 1 with MIE = 1 and jump_flag_i = 1, jump_addr_i 64'h8000_0200 -> mepc 64'h8000_0200, mcause 64'h8000_0000_0000_0007. With MIE = 0: no action, stall stays 0.
- MRET with mstatus 64'h80, mepc 64'h8000_0014 -> mstatus write 64'h88 at T+1; int_assert_o with int_addr_o 64'h8000_0014 at T+2.
- ECALL and timer in the same cycle with MIE = 1 -> mcause 64'd11 only; no second trap before MRET.
- rst asserted at T+2 of an ECALL sequence -> all outputs 0 from T+3; no mstatus write and no int_assert_o.
- EBREAK with mtvec 64'h8000_1003 -> mcause 64'd3, int_addr_o 64'h8000_1000.
